// File: rtl/lsu_mem_master.sv
// Load/store unit memory master: one request at a time, sub-word stores done as
// read-modify-write on a word-addressed memory, loads extended to 32 bits.
module lsu_mem_master #(
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state, state_nxt;
    logic        we_q, uns_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, word_q;

    logic        req_bad;
    logic [2:0]  sz_bytes;
    logic [32:0] end_addr;
    logic [31:0] merged, ext;
    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    // Accept-time legality: alignment, illegal size, and range against memory size
    always_comb begin
        req_bad  = 1'b0;
        sz_bytes = 3'd1;
        case (req_size)
            2'b00: sz_bytes = 3'd1;
            2'b01: begin sz_bytes = 3'd2; req_bad = req_addr[0]; end
            2'b10: begin sz_bytes = 3'd4; req_bad = (req_addr[1:0] != 2'b00); end
            default: req_bad = 1'b1;
        endcase
        end_addr = {1'b0, req_addr} + {30'b0, sz_bytes};
        if (end_addr > 33'(MEM_BYTES)) req_bad = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) begin
                if (req_bad)                         state_nxt = RESP;
                else if (req_we && req_size == 2'b10) state_nxt = WR;
                else                                 state_nxt = RD;
            end
            RD:   state_nxt = we_q ? WR : RESP;
            WR:   state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            word_q  <= 32'h0;
        end else begin
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                err_q   <= req_bad;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == RD) word_q <= mem_rdata;
        end
    end

    // Lane selection and store merge are little-endian on addr_q[1:0]
    always_comb begin
        sel_b  = word_q[{addr_q[1:0], 3'b000} +: 8];
        sel_h  = addr_q[1] ? word_q[31:16] : word_q[15:0];
        merged = word_q;
        case (size_q)
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
        case (size_q)
            2'b00:   ext = uns_q ? {24'h0, sel_b} : {{24{sel_b[7]}}, sel_b};
            2'b01:   ext = uns_q ? {16'h0, sel_h} : {{16{sel_h[15]}}, sel_h};
            default: ext = word_q;
        endcase
    end

    // rst_n gating keeps req_ready low during reset even though state reads IDLE
    assign req_ready  = (state == IDLE) && rst_n;
    assign mem_read   = (state == RD);
    assign mem_write  = (state == WR);
    assign resp_valid = (state == RESP);
    assign resp_err   = (state == RESP) && err_q;
    assign resp_rdata = (state == RESP && !err_q && !we_q) ? ext : 32'h0;
    assign mem_addr   = (state == RD || state == WR) ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wdata  = (state == WR) ? merged : 32'h0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a behavioral word memory.
module tb_lsu_mem_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic [1:0]  req_size = 2'b00;
    logic        req_ready, resp_valid, resp_err, mem_write, mem_read;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:1023];
    int n_checks = 0;
    int n_fail   = 0;

    // results of the last do_req
    int          lat;
    logic        got, saw_rd, saw_wr, r_err, both;
    logic [31:0] r_data, wd;

    always #5 clk = ~clk;

    lsu_mem_master #(.MEM_BYTES(4096)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_read(mem_read), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem_read ? mem[mem_addr[11:2]] : 32'h0;
    always @(posedge clk) if (mem_write) mem[mem_addr[11:2]] <= mem_wdata;

    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] sz, input logic uns);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        req_size = sz; req_unsigned = uns;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; got = 0; saw_rd = 0; saw_wr = 0; both = 0;
        r_data = 32'hx; r_err = 1'bx; wd = 32'h0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (mem_read) saw_rd = 1;
            if (mem_write) begin saw_wr = 1; wd = mem_wdata; end
            if (mem_read && mem_write) both = 1;
            if (resp_valid) begin got = 1; r_data = resp_rdata; r_err = resp_err; end
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b0 ||
            resp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b rv=%b err=%b rd=%b wr=%b rdata=%h addr=%h wdata=%h, required all 0",
                     req_ready, resp_valid, resp_err, mem_read, mem_write, resp_rdata, mem_addr, mem_wdata);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_after_reset: got %b required 1", req_ready);
        end
    endtask

    task automatic chk_load(input string nm, input logic [31:0] exp);
        n_checks++;
        if (!got || lat != 2 || r_err !== 1'b0 || r_data !== exp || saw_wr) begin
            n_fail++;
            $display("FAIL %s: got=%b lat=%0d err=%b data=%h wr=%b, required lat=2 err=0 data=%h wr=0",
                     nm, got, lat, r_err, r_data, saw_wr, exp);
        end
    endtask

    task automatic test_loads();
        do_req(0, 32'h13, 0, 2'b00, 0); chk_load("lb_0x13", 32'hFFFFFF88);
        do_req(0, 32'h13, 0, 2'b00, 1); chk_load("lbu_0x13", 32'h00000088);
        do_req(0, 32'h12, 0, 2'b01, 0); chk_load("lh_0x12", 32'hFFFF8899);
        do_req(0, 32'h10, 0, 2'b01, 1); chk_load("lhu_0x10", 32'h0000AABB);
        do_req(0, 32'h11, 0, 2'b00, 0); chk_load("lb_0x11", 32'hFFFFFFAA);
        do_req(0, 32'h10, 0, 2'b10, 0); chk_load("lw_0x10", 32'h8899AABB);
        do_req(0, 32'hFFF, 0, 2'b00, 0); chk_load("lb_top_byte", 32'hFFFFFFCA);
        do_req(0, 32'hFFC, 0, 2'b10, 1); chk_load("lw_top_word", 32'hCAFEF00D);
    endtask

    task automatic test_stores();
        do_req(1, 32'h11, 32'hFFFFFF5A, 2'b00, 0);
        n_checks++;
        if (!got || lat != 3 || r_err !== 0 || r_data !== 0 || !saw_rd || !saw_wr || both ||
            wd !== 32'h88995ABB || mem[4] !== 32'h88995ABB) begin
            n_fail++;
            $display("FAIL sb_0x11: lat=%0d err=%b data=%h rd=%b wr=%b wdata=%h mem=%h, required lat=3 wdata=88995abb",
                     lat, r_err, r_data, saw_rd, saw_wr, wd, mem[4]);
        end
        mem[4] = 32'h8899AABB;
        do_req(1, 32'h12, 32'h0000BEEF, 2'b01, 0);
        n_checks++;
        if (!got || lat != 3 || wd !== 32'hBEEFAABB || mem[4] !== 32'hBEEFAABB || both) begin
            n_fail++;
            $display("FAIL sh_0x12: lat=%0d wdata=%h mem=%h, required lat=3 beefaabb", lat, wd, mem[4]);
        end
        mem[4] = 32'h8899AABB;
        do_req(1, 32'h20, 32'h12345678, 2'b10, 0);
        n_checks++;
        if (!got || lat != 2 || r_err !== 0 || saw_rd || !saw_wr || wd !== 32'h12345678 ||
            mem[8] !== 32'h12345678) begin
            n_fail++;
            $display("FAIL sw_0x20: lat=%0d rd=%b wr=%b wdata=%h mem=%h, required lat=2 rd=0 12345678",
                     lat, saw_rd, saw_wr, wd, mem[8]);
        end
    endtask

    task automatic chk_err(input string nm);
        n_checks++;
        if (!got || lat != 1 || r_err !== 1'b1 || r_data !== 32'h0 || saw_rd || saw_wr) begin
            n_fail++;
            $display("FAIL %s: got=%b lat=%0d err=%b data=%h rd=%b wr=%b, required lat=1 err=1 data=0 no access",
                     nm, got, lat, r_err, r_data, saw_rd, saw_wr);
        end
    endtask

    task automatic test_errors();
        do_req(1, 32'h12, 32'h12345678, 2'b10, 0); chk_err("sw_misaligned");
        n_checks++;
        if (mem[4] !== 32'h8899AABB) begin
            n_fail++; $display("FAIL sw_misaligned_mem: got %h required 8899aabb", mem[4]);
        end
        do_req(0, 32'h1000, 0, 2'b10, 0); chk_err("lw_out_of_range");
        do_req(0, 32'h10, 0, 2'b11, 0);   chk_err("size_illegal");
        do_req(0, 32'h11, 0, 2'b01, 0);   chk_err("lh_odd");
        do_req(0, 32'hFFE, 0, 2'b10, 0);  chk_err("lw_straddle");
    endtask

    task automatic test_reset_mid();
        logic seen_wr, seen_resp;
        seen_wr = 0; seen_resp = 0;
        @(negedge clk);
        req_valid = 1; req_we = 1; req_addr = 32'h10; req_wdata = 32'hBEEF; req_size = 2'b01;
        @(posedge clk);
        #1 req_valid = 0;
        for (int i = 0; i < 6 && !seen_wr; i++) begin
            @(negedge clk);
            if (mem_write) seen_wr = 1;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (!seen_wr || mem_write !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_wr: reached_wr=%b mem_write=%b ready=%b, required 1/0/0",
                     seen_wr, mem_write, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) seen_resp = 1;
            if (i == 0) begin
                n_checks++;
                if (req_ready !== 1'b1) begin
                    n_fail++; $display("FAIL reset_mid_ready: got %b required 1", req_ready);
                end
            end
        end
        n_checks++;
        if (mem[4] !== 32'h8899AABB || seen_resp) begin
            n_fail++;
            $display("FAIL reset_mid_discard: mem=%h resp_seen=%b, required 8899aabb 0", mem[4], seen_resp);
        end
    endtask

    task automatic test_back_to_back();
        int nresp, c1, c2, cr;
        logic [31:0] d1, d2;
        nresp = 0; c1 = 0; c2 = 0; cr = 0; d1 = 0; d2 = 0;
        @(negedge clk);
        req_valid = 1; req_we = 0; req_addr = 32'h13; req_size = 2'b00; req_unsigned = 1;
        @(posedge clk);
        #1 req_addr = 32'h10; req_size = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                nresp++;
                if (nresp == 1) begin c1 = k; d1 = resp_rdata; end
                else begin c2 = k; d2 = resp_rdata; end
            end
            if (req_ready && nresp == 1 && cr == 0) begin
                cr = k;
                @(posedge clk);
                #1 req_valid = 0;
            end
        end
        req_valid = 0;
        n_checks++;
        if (nresp != 2 || c1 != 2 || cr != 3 || c2 != 5 || d1 !== 32'h88 || d2 !== 32'hAABB) begin
            n_fail++;
            $display("FAIL back_to_back: nresp=%0d c1=%0d ready=%0d c2=%0d d1=%h d2=%h, required 2/2/3/5/88/aabb",
                     nresp, c1, cr, c2, d1, d2);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[4]    = 32'h8899AABB;
        mem[1023] = 32'hCAFEF00D;
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end
endmodule
